ks_operand_sequencer: RTL and testbench

// - Upstream/downstream wrapper stage for the 8-bit Kogge-Stone adder.
// - Collects two operand bytes (A, then B) from one byte stream and drives them to
//   the adder as registered, stable operands.
// - Waits a programmable settle time, captures sum/cout and holds the result behind
//   a valid/ready handshake.
// - Sits between the chip input pins and the adder; its result port feeds the output pins.

---
 rtl/ks_operand_sequencer_pkg.sv | 18 +
 rtl/ks_operand_sequencer_if.sv | 29 ++
 rtl/ks_operand_sequencer.sv | 124 ++++++++++++
 tb/tb_ks_operand_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_operand_sequencer_pkg.sv
// Shared definitions for the Kogge-Stone operand sequencer.
// Contents:
//   KS_W        - operand/sum width in bits
//   MAX_ADD_LAT - largest supported settle delay (fits the 2-bit counter)
//   state_t     - sequencer states, 2-bit encoding
package ks_pkg;

  localparam int KS_W        = 8;
  localparam int MAX_ADD_LAT = 3;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/ks_operand_sequencer_if.sv
// Byte-stream input and result handshake of the operand sequencer.
// Signals:
//   in_data/in_valid/in_ready      - operand byte stream (A, then B)
//   res_sum/res_cout/res_valid/res_ready - captured result handshake
// Modports:
//   master - producer/consumer side (drives in_*, res_ready)
//   slave  - sequencer side (drives in_ready, res_*)
interface ks_operand_sequencer_if;
  import ks_pkg::*;

  logic [KS_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [KS_W-1:0] res_sum;
  logic            res_cout;
  logic            res_valid;
  logic            res_ready;

  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_sum, res_cout, res_valid
  );

  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_sum, res_cout, res_valid
  );

endinterface

// File: rtl/ks_operand_sequencer.sv
// Operand sequencer wrapped around the 8-bit Kogge-Stone adder.
// Collects operand A then B from a byte stream, presents them as registered
// operands, waits ADD_LAT settle cycles, captures sum/carry and holds the
// result behind a valid/ready handshake.
// Ports:
//   clk, rst   - clock; asynchronous active-high reset
//   flush      - synchronous abort back to S_A (operands, op_count kept)
//   bus        - slave modport: in_* byte stream, res_* result handshake
//   add_a/b    - registered operands to the adder
//   add_sum/cout - combinational adder outputs
//   op_count   - consumed-result counter, wraps modulo 2^CNT_W
// ADD_LAT must lie in 0..MAX_ADD_LAT.
module ks_operand_sequencer
  import ks_pkg::*;
#(
  parameter int ADD_LAT = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  ks_operand_sequencer_if.slave bus,
  output logic [KS_W-1:0]      add_a,
  output logic [KS_W-1:0]      add_b,
  input  logic [KS_W-1:0]      add_sum,
  input  logic                 add_cout,
  output logic [CNT_W-1:0]     op_count
);

  localparam logic [1:0] LAT_INIT = 2'(ADD_LAT);

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [KS_W-1:0]   add_a_reg, add_a_next;
  logic [KS_W-1:0]   add_b_reg, add_b_next;
  logic [KS_W-1:0]   res_sum_reg, res_sum_next;
  logic              res_cout_reg, res_cout_next;
  logic              res_valid_reg, res_valid_next;
  logic [CNT_W-1:0]  op_count_reg, op_count_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_A;
      cnt_reg       <= 2'd0;
      add_a_reg     <= '0;
      add_b_reg     <= '0;
      res_sum_reg   <= '0;
      res_cout_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      add_a_reg     <= add_a_next;
      add_b_reg     <= add_b_next;
      res_sum_reg   <= res_sum_next;
      res_cout_reg  <= res_cout_next;
      res_valid_reg <= res_valid_next;
      op_count_reg  <= op_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    add_a_next     = add_a_reg;
    add_b_next     = add_b_reg;
    res_sum_next   = res_sum_reg;
    res_cout_next  = res_cout_reg;
    res_valid_next = res_valid_reg;
    op_count_next  = op_count_reg;
    // flush wins over both handshakes: nothing is accepted or counted.
    if (flush) begin
      state_next     = S_A;
      res_valid_next = 1'b0;
      cnt_next       = 2'd0;
    end else begin
      case (state_reg)
        S_A: begin
          if (bus.in_valid) begin
            add_a_next = bus.in_data;
            state_next = S_B;
          end
        end
        S_B: begin
          if (bus.in_valid) begin
            add_b_next = bus.in_data;
            cnt_next   = LAT_INIT;
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          // Operands became stable at entry; sample once the settle count expires.
          if (cnt_reg == 2'd0) begin
            res_sum_next   = add_sum;
            res_cout_next  = add_cout;
            res_valid_next = 1'b1;
            state_next     = S_OUT;
          end else begin
            cnt_next = cnt_reg - 2'd1;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            res_valid_next = 1'b0;
            op_count_next  = op_count_reg + CNT_W'(1);
            state_next     = S_A;
          end
        end
        default: state_next = S_A;
      endcase
    end
  end

  // Depends on state only, so no combinational path from in_valid/res_ready.
  assign bus.in_ready  = (state_reg == S_A) || (state_reg == S_B);
  assign bus.res_sum   = res_sum_reg;
  assign bus.res_cout  = res_cout_reg;
  assign bus.res_valid = res_valid_reg;
  assign add_a         = add_a_reg;
  assign add_b         = add_b_reg;
  assign op_count      = op_count_reg;

endmodule

// File: tb/tb_ks_operand_sequencer.sv
// Self-checking bench: dut0 (ADD_LAT=0, CNT_W=8), dut3 (ADD_LAT=3, CNT_W=4).
module tb_ks_operand_sequencer;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic flush0 = 1'b0;
  logic flush3 = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  ks_operand_sequencer_if if0();
  ks_operand_sequencer_if if3();

  logic [7:0] add_a0, add_b0, add_sum0, add_a3, add_b3, add_sum3;
  logic       add_cout0, add_cout3;
  logic [7:0] op_count0;
  logic [3:0] op_count3;

  // Behavioural stand-in for the Kogge-Stone adder.
  assign {add_cout0, add_sum0} = {1'b0, add_a0} + {1'b0, add_b0};
  assign {add_cout3, add_sum3} = {1'b0, add_a3} + {1'b0, add_b3};

  always #5 clk = clk_en ? ~clk : 1'b0;

  ks_operand_sequencer #(.ADD_LAT(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .bus(if0),
    .add_a(add_a0), .add_b(add_b0), .add_sum(add_sum0), .add_cout(add_cout0),
    .op_count(op_count0)
  );

  ks_operand_sequencer #(.ADD_LAT(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .bus(if3),
    .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3), .add_cout(add_cout3),
    .op_count(op_count3)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #2;
    tests_run++;
    if ({if0.in_ready, if0.res_valid, if0.res_cout, if0.res_sum, add_a0, add_b0, op_count0} !== {1'b1, 1'b0, 1'b0, 24'h0, 8'h0}) begin
      tests_failed++;
      $display("FAIL reset_dut0: got rdy=%b vld=%b cout=%b sum=%h a=%h b=%h cnt=%h, expected 1 0 0 00 00 00 00",
               if0.in_ready, if0.res_valid, if0.res_cout, if0.res_sum, add_a0, add_b0, op_count0);
    end
    tests_run++;
    if ({if3.in_ready, if3.res_valid, if3.res_cout, if3.res_sum, add_a3, add_b3, op_count3} !== {1'b1, 1'b0, 1'b0, 24'h0, 4'h0}) begin
      tests_failed++;
      $display("FAIL reset_dut3: got rdy=%b vld=%b cout=%b sum=%h a=%h b=%h cnt=%h, expected 1 0 0 00 00 00 0",
               if3.in_ready, if3.res_valid, if3.res_cout, if3.res_sum, add_a3, add_b3, op_count3);
    end
    #3 rst = 1'b0;
    clk_en = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_add_lat0();
    if0.in_valid = 1'b1; if0.in_data = 8'h0F;
    cycle();
    if0.in_data = 8'h01;
    cycle();                       // edge E: B accepted
    if0.in_valid = 1'b0;
    tests_run++;
    if (if0.res_valid !== 1'b0 || if0.in_ready !== 1'b0 || add_a0 !== 8'h0F || add_b0 !== 8'h01) begin
      tests_failed++;
      $display("FAIL lat0_after_b: got vld=%b rdy=%b a=%h b=%h, expected 0 0 0f 01",
               if0.res_valid, if0.in_ready, add_a0, add_b0);
    end
    cycle();                       // edge E+1
    tests_run++;
    if (if0.res_valid !== 1'b1 || if0.res_sum !== 8'h10 || if0.res_cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat0_result: got vld=%b sum=%h cout=%b, expected 1 10 0",
               if0.res_valid, if0.res_sum, if0.res_cout);
    end
    if0.res_ready = 1'b1;
    cycle();
    if0.res_ready = 1'b0;
    tests_run++;
    if (if0.res_valid !== 1'b0 || op_count0 !== 8'd1 || if0.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat0_consume: got vld=%b cnt=%0d rdy=%b, expected 0 1 1",
               if0.res_valid, op_count0, if0.in_ready);
    end
    $display("[TB] 0x0F+0x01 lat0: sum=%h cout=%b", if0.res_sum, if0.res_cout);
  endtask

  task automatic test_carry_backpressure();
    if0.in_valid = 1'b1; if0.in_data = 8'hFF;
    cycle();
    if0.in_data = 8'h01;
    cycle();
    if0.in_data = 8'h55;           // held valid but must be ignored
    cycle();
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (if0.res_valid !== 1'b1 || if0.res_sum !== 8'h00 || if0.res_cout !== 1'b1 ||
          if0.in_ready !== 1'b0 || add_a0 !== 8'hFF) begin
        tests_failed++;
        $display("FAIL backpressure_%0d: got vld=%b sum=%h cout=%b rdy=%b a=%h, expected 1 00 1 0 ff",
                 k, if0.res_valid, if0.res_sum, if0.res_cout, if0.in_ready, add_a0);
      end
      cycle();
    end
    if0.in_valid = 1'b0;
    if0.res_ready = 1'b1;
    cycle();
    if0.res_ready = 1'b0;
    tests_run++;
    if (op_count0 !== 8'd2 || if0.res_valid !== 1'b0 || if0.res_sum !== 8'h00) begin
      tests_failed++;
      $display("FAIL carry_consume: got cnt=%0d vld=%b sum=%h, expected 2 0 00",
               op_count0, if0.res_valid, if0.res_sum);
    end
    $display("[TB] 0xFF+0x01 backpressure: sum=%h cout=%b cnt=%0d", if0.res_sum, if0.res_cout, op_count0);
  endtask

  task automatic test_add_lat3();
    if3.in_valid = 1'b1; if3.in_data = 8'h80;
    cycle();
    cycle();                       // edge E: B accepted
    for (int k = 1; k <= 3; k++) begin
      if3.in_valid = (k == 1);
      if3.in_data  = 8'h77;
      cycle();                     // edge E+k
      tests_run++;
      if (if3.res_valid !== 1'b0 || if3.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL lat3_wait_%0d: got vld=%b rdy=%b, expected 0 0", k, if3.res_valid, if3.in_ready);
      end
    end
    if3.in_valid = 1'b0;
    cycle();                       // edge E+4
    tests_run++;
    if (if3.res_valid !== 1'b1 || if3.res_sum !== 8'h00 || if3.res_cout !== 1'b1 ||
        add_a3 !== 8'h80 || add_b3 !== 8'h80) begin
      tests_failed++;
      $display("FAIL lat3_result: got vld=%b sum=%h cout=%b a=%h b=%h, expected 1 00 1 80 80",
               if3.res_valid, if3.res_sum, if3.res_cout, add_a3, add_b3);
    end
    if3.res_ready = 1'b1;
    cycle();
    if3.res_ready = 1'b0;
    tests_run++;
    if (op_count3 !== 4'd1) begin
      tests_failed++;
      $display("FAIL lat3_consume: got cnt=%0d, expected 1", op_count3);
    end
    $display("[TB] 0x80+0x80 lat3: sum=%h cout=%b", if3.res_sum, if3.res_cout);
  endtask

  task automatic test_flush();
    if0.in_valid = 1'b1; if0.in_data = 8'hAA;
    cycle();                       // in S_B
    if0.in_data = 8'hBB;
    flush0 = 1'b1;
    cycle();
    flush0 = 1'b0;
    if0.in_valid = 1'b0;
    tests_run++;
    if (if0.in_ready !== 1'b1 || add_a0 !== 8'hAA || add_b0 !== 8'h01 || if0.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_b: got rdy=%b a=%h b=%h vld=%b, expected 1 aa 01 0",
               if0.in_ready, add_a0, add_b0, if0.res_valid);
    end
    cycle();                       // still S_A after an idle cycle
    if0.in_valid = 1'b1; if0.in_data = 8'h12;
    cycle();
    if0.in_data = 8'h34;
    cycle();
    if0.in_valid = 1'b0;
    cycle();
    tests_run++;
    if (if0.res_valid !== 1'b1 || if0.res_sum !== 8'h46 || if0.res_cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_next_pair: got vld=%b sum=%h cout=%b, expected 1 46 0",
               if0.res_valid, if0.res_sum, if0.res_cout);
    end
    if0.res_ready = 1'b1;
    flush0 = 1'b1;
    cycle();
    if0.res_ready = 1'b0;
    flush0 = 1'b0;
    tests_run++;
    if (if0.res_valid !== 1'b0 || op_count0 !== 8'd2 || if0.in_ready !== 1'b1 || if0.res_sum !== 8'h46) begin
      tests_failed++;
      $display("FAIL flush_vs_ready: got vld=%b cnt=%0d rdy=%b sum=%h, expected 0 2 1 46",
               if0.res_valid, op_count0, if0.in_ready, if0.res_sum);
    end
    $display("[TB] flush: 0x12+0x34 sum=%h cnt=%0d", if0.res_sum, op_count0);
  endtask

  task automatic test_random();
    int exp_cnt;
    int waited;
    int errs_before;
    logic [7:0] a, b;
    logic [8:0] exp_res;
    exp_cnt = 1;
    errs_before = tests_failed;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp_res = {1'b0, a} + {1'b0, b};
      repeat ($urandom_range(0, 2)) cycle();
      if3.in_valid = 1'b1; if3.in_data = a;
      cycle();
      if3.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) cycle();
      if3.in_valid = 1'b1; if3.in_data = b;
      cycle();
      if3.in_valid = 1'b0;
      waited = 0;
      while (if3.res_valid !== 1'b1 && waited < 20) begin
        cycle();
        waited++;
      end
      tests_run++;
      if (if3.res_valid !== 1'b1 || waited != 4) begin
        tests_failed++;
        $display("FAIL rand_latency_%0d: got vld=%b after %0d cycles, expected 1 after 4", n, if3.res_valid, waited);
      end
      repeat ($urandom_range(0, 3)) cycle();
      tests_run++;
      if (if3.res_valid !== 1'b1 || {if3.res_cout, if3.res_sum} !== exp_res) begin
        tests_failed++;
        $display("FAIL rand_result_%0d: %h+%h got vld=%b res=%h, expected 1 %h",
                 n, a, b, if3.res_valid, {if3.res_cout, if3.res_sum}, exp_res);
      end
      if3.res_ready = 1'b1;
      cycle();
      if3.res_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 16;
      tests_run++;
      if (op_count3 !== 4'(exp_cnt)) begin
        tests_failed++;
        $display("FAIL rand_count_%0d: got %0d, expected %0d", n, op_count3, exp_cnt);
      end
    end
    $display("[TB] random 1000 ops: %0d failures, final op_count=%0d", tests_failed - errs_before, op_count3);
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.res_ready = 1'b0;
    if3.in_valid = 1'b0; if3.in_data = 8'h00; if3.res_ready = 1'b0;
    test_reset();
    cycle();
    test_add_lat0();
    test_carry_backpressure();
    test_add_lat3();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
